// File: rtl/gmii_udp_cmd_rx.sv
// GMII receive-side command parser: filters IPv4/UDP frames addressed to this
// board, checks the Ethernet FCS and presents one register-write command per
// accepted frame on a valid/ready interface.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | line quiet or between frames; waits for first 0x55
// S_PREAMBLE | inside preamble; waits for SFD (0xD5)
// S_BODY     | frame bytes: index, CRC, header compare, field capture
// S_CHECK    | one cycle: accept (commit command) or drop (count)
// S_DISCARD  | malformed start or mid-frame reset; waits for rx_dv low
module gmii_udp_cmd_rx #(
  parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_02,
  parameter logic [31:0] LOCAL_IP = 32'hC0A80002,
  parameter logic [15:0] CMD_PORT = 16'd10002,
  parameter logic [7:0]  MAGIC    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  gmii_rx_d,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [15:0] cmd_addr,
  output logic [31:0] cmd_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_dropped
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_BODY,
    S_CHECK,
    S_DISCARD
  } state_t;

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] IDX_MAX     = 11'h7FF;

  state_t      state_q, state_d;
  logic [10:0] idx_q, idx_d;
  logic [31:0] crc_q, crc_d;
  logic        hdr_ok_q, hdr_ok_d;
  logic        er_seen_q, er_seen_d;
  logic [15:0] sh_addr_q, sh_addr_d;
  logic [31:0] sh_data_q, sh_data_d;
  logic [15:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_data_q, cmd_data_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [15:0] frames_ok_q, frames_ok_d;
  logic [15:0] frames_dropped_q, frames_dropped_d;

  logic byte_match;
  logic consume;
  logic accept;

  // One byte of reflected CRC-32, data LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Compare the current body byte against the required value at its index.
  always_comb begin
    byte_match = 1'b1;
    case (idx_q)
      11'd0:   byte_match = (gmii_rx_d == MAC_ADDR[47:40]);
      11'd1:   byte_match = (gmii_rx_d == MAC_ADDR[39:32]);
      11'd2:   byte_match = (gmii_rx_d == MAC_ADDR[31:24]);
      11'd3:   byte_match = (gmii_rx_d == MAC_ADDR[23:16]);
      11'd4:   byte_match = (gmii_rx_d == MAC_ADDR[15:8]);
      11'd5:   byte_match = (gmii_rx_d == MAC_ADDR[7:0]);
      11'd12:  byte_match = (gmii_rx_d == 8'h08);
      11'd13:  byte_match = (gmii_rx_d == 8'h00);
      11'd14:  byte_match = (gmii_rx_d == 8'h45);
      11'd23:  byte_match = (gmii_rx_d == 8'h11);
      11'd30:  byte_match = (gmii_rx_d == LOCAL_IP[31:24]);
      11'd31:  byte_match = (gmii_rx_d == LOCAL_IP[23:16]);
      11'd32:  byte_match = (gmii_rx_d == LOCAL_IP[15:8]);
      11'd33:  byte_match = (gmii_rx_d == LOCAL_IP[7:0]);
      11'd36:  byte_match = (gmii_rx_d == CMD_PORT[15:8]);
      11'd37:  byte_match = (gmii_rx_d == CMD_PORT[7:0]);
      11'd42:  byte_match = (gmii_rx_d == MAGIC);
      default: byte_match = 1'b1;
    endcase
  end

  // Next-state, frame bookkeeping and command commit.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    crc_d            = crc_q;
    hdr_ok_d         = hdr_ok_q;
    er_seen_d        = er_seen_q;
    sh_addr_d        = sh_addr_q;
    sh_data_d        = sh_data_q;
    cmd_addr_d       = cmd_addr_q;
    cmd_data_d       = cmd_data_q;
    cmd_valid_d      = cmd_valid_q;
    frames_ok_d      = frames_ok_q;
    frames_dropped_d = frames_dropped_q;

    consume = cmd_valid_q && cmd_ready;
    accept  = hdr_ok_q && (crc_q == CRC_RESIDUE) && !er_seen_q &&
              (idx_q >= 11'd64) && (idx_q <= 11'd1518) &&
              (!cmd_valid_q || consume);

    if (consume) cmd_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Data bytes that are not preamble mean we joined mid-frame.
        if (gmii_rx_dv) state_d = (gmii_rx_d == 8'h55) ? S_PREAMBLE : S_DISCARD;
      end
      S_PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_d = S_IDLE;
        end else if (gmii_rx_d == 8'hD5) begin
          state_d   = S_BODY;
          idx_d     = 11'd0;
          crc_d     = 32'hFFFFFFFF;
          hdr_ok_d  = 1'b1;
          er_seen_d = 1'b0;
        end else if (gmii_rx_d != 8'h55) begin
          state_d = S_DISCARD;
        end
      end
      S_BODY: begin
        if (gmii_rx_dv) begin
          // Saturate so oversize frames still fail the length check.
          idx_d    = (idx_q == IDX_MAX) ? idx_q : idx_q + 11'd1;
          crc_d    = crc32_byte(crc_q, gmii_rx_d);
          hdr_ok_d = hdr_ok_q & byte_match;
          if (gmii_rx_er) er_seen_d = 1'b1;
          case (idx_q)
            11'd43:  sh_addr_d[15:8]  = gmii_rx_d;
            11'd44:  sh_addr_d[7:0]   = gmii_rx_d;
            11'd45:  sh_data_d[31:24] = gmii_rx_d;
            11'd46:  sh_data_d[23:16] = gmii_rx_d;
            11'd47:  sh_data_d[15:8]  = gmii_rx_d;
            11'd48:  sh_data_d[7:0]   = gmii_rx_d;
            default: ;
          endcase
        end else begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (accept) begin
          cmd_addr_d  = sh_addr_q;
          cmd_data_d  = sh_data_q;
          cmd_valid_d = 1'b1;
          if (frames_ok_q != 16'hFFFF) frames_ok_d = frames_ok_q + 16'd1;
        end else begin
          if (frames_dropped_q != 16'hFFFF) frames_dropped_d = frames_dropped_q + 16'd1;
        end
      end
      S_DISCARD: begin
        if (!gmii_rx_dv) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      idx_q            <= 11'd0;
      crc_q            <= 32'hFFFFFFFF;
      hdr_ok_q         <= 1'b0;
      er_seen_q        <= 1'b0;
      sh_addr_q        <= 16'd0;
      sh_data_q        <= 32'd0;
      cmd_addr_q       <= 16'd0;
      cmd_data_q       <= 32'd0;
      cmd_valid_q      <= 1'b0;
      frames_ok_q      <= 16'd0;
      frames_dropped_q <= 16'd0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      crc_q            <= crc_d;
      hdr_ok_q         <= hdr_ok_d;
      er_seen_q        <= er_seen_d;
      sh_addr_q        <= sh_addr_d;
      sh_data_q        <= sh_data_d;
      cmd_addr_q       <= cmd_addr_d;
      cmd_data_q       <= cmd_data_d;
      cmd_valid_q      <= cmd_valid_d;
      frames_ok_q      <= frames_ok_d;
      frames_dropped_q <= frames_dropped_d;
    end
  end

  assign cmd_addr       = cmd_addr_q;
  assign cmd_data       = cmd_data_q;
  assign cmd_valid      = cmd_valid_q;
  assign frames_ok      = frames_ok_q;
  assign frames_dropped = frames_dropped_q;

endmodule

// File: doc/gmii_udp_cmd_rx.md
# gmii_udp_cmd_rx

Receive-side command parser for the GMII link. It consumes raw GMII receive bytes from the PHY in the 125 MHz Ethernet domain and filters for IPv4/UDP frames addressed to this board's MAC, IP and command port. It extracts one register-write command per frame, checks the Ethernet FCS, and presents the command on a valid/ready interface. Committed commands feed the control register file (frequency word, gain, filter select, enable) alongside the RP2040 SPI path.

## Interface
- `MAC_ADDR`, default 48'h02_00_00_00_00_02: destination MAC accepted.
- `LOCAL_IP`, default 32'hC0A80002: destination IPv4 address accepted (192.168.0.2).
- `CMD_PORT`, default 16'd10002: destination UDP port accepted.
- `MAGIC`, default 8'hA5: first UDP payload byte required.
- `clk` input 1: 125 MHz GMII receive clock; one clock only.
- `rst_n` input 1: reset; synchronous, active-low.
- `gmii_rx_d` input 8: GMII receive data.
- `gmii_rx_dv` input 1: GMII receive data valid.
- `gmii_rx_er` input 1: GMII receive error.
- `cmd_addr` output 16: register address of the committed command.
- `cmd_data` output 32: write data of the committed command.
- `cmd_valid` output 1: command available; held until accepted.
- `cmd_ready` input 1: consumer accepts when `cmd_valid && cmd_ready`.
- `frames_ok` output 16: count of accepted commands; saturates at 16'hFFFF.
- `frames_dropped` output 16: count of rejected frames that reached the body; saturates at 16'hFFFF.

## Operation
- States:
  - IDLE: waits for `gmii_rx_dv`=1 with `gmii_rx_d`=8'h55, then enters PREAMBLE.
  - PREAMBLE: stays on 8'h55. On 8'hD5 (SFD), goes to BODY and clears the byte counter. Any other byte goes to DISCARD. If `gmii_rx_dv` falls, returns to IDLE. Neither exit is counted.
  - BODY: each byte with `gmii_rx_dv`=1 increments the 11-bit byte index (0 = first destination-MAC byte) and updates the CRC. Header fields are compared on the fly. When `gmii_rx_dv` falls, goes to CHECK.
  - CHECK (1 cycle): decides accept or drop, then returns to IDLE.
  - DISCARD: waits for `gmii_rx_dv`=0, then returns to IDLE.
- Required byte values, by byte index (multi-byte fields are big-endian):
  - 0–5: `MAC_ADDR`.
  - 12–13: 16'h0800.
  - 14: 8'h45.
  - 23: 8'h11.
  - 30–33: `LOCAL_IP`.
  - 36–37: `CMD_PORT`.
  - 42: `MAGIC`.
- Captured fields: `cmd_addr` = bytes 43–44; `cmd_data` = bytes 45–48. Bytes 49 onward are ignored except for the CRC. Captured values go to shadow registers first. The outputs update only on accept.
- CRC: reflected CRC-32, polynomial 32'hEDB88320, initialised to 32'hFFFFFFFF on SFD. It is updated byte-serially (LSB first) over every BODY byte, including the 4 FCS bytes. The FCS is good iff the register equals 32'hDEBB20E3 at CHECK.
- Accept in CHECK iff all of the following hold:
  - every header compare matched;
  - FCS good;
  - no `gmii_rx_er` seen during BODY;
  - total bytes 64..1518 inclusive;
  - `cmd_valid`=0, or it is being consumed this same cycle.
- Otherwise the frame is dropped. This includes frames that fail only the address/port/magic filters.
- On accept: `cmd_addr`/`cmd_data` are loaded from the shadows, `cmd_valid` is set and `frames_ok` increments. On drop: `frames_dropped` increments. The existing pending command is never overwritten.
- `cmd_valid` clears on the cycle after `cmd_valid && cmd_ready`. If an accept coincides with that consumption, `cmd_valid` stays 1 with the new values.
- `gmii_rx_er` in IDLE or PREAMBLE has no effect.

## Timing
- Reset (`rst_n`=0 at a `clk` edge):
  - state IDLE;
  - `cmd_valid`=0, `cmd_addr`=0, `cmd_data`=0;
  - `frames_ok`=0, `frames_dropped`=0.
- Reset mid-frame abandons the frame with no count. The remainder of that frame is ignored until `gmii_rx_dv` goes low, because the block resets into IDLE and the non-0x55 data bytes route it to DISCARD.
- Latency: `cmd_valid` rises 2 cycles after the last FCS byte is sampled. That is 1 cycle to see `gmii_rx_dv`=0 (entering CHECK), plus 1 registered cycle.
- Throughput: back-to-back frames with the minimum 12-byte IPG are fully supported, since CHECK completes within the IPG.
- Counters update in the same cycle as `cmd_valid`.

## Test plan
- Good 64-byte frame: MAC/IP/port match, magic 8'hA5, addr 16'h0010, data 32'h12345678, correct FCS -> `cmd_valid`=1 two cycles after the last byte, `cmd_addr`=16'h0010, `cmd_data`=32'h12345678, `frames_ok`=1, `frames_dropped`=0.
- Same frame with FCS bit 0 flipped -> no `cmd_valid`, `frames_dropped`=1.
- Frame with UDP port 10001 -> dropped, `frames_dropped`=1. Same for wrong MAC, wrong ethertype 16'h0806, and magic 8'h00 (one case each).
- Good frame with `gmii_rx_er` pulsed at byte 20 -> dropped. A 60-byte frame (runt) -> dropped.
- Backpressure: `cmd_ready`=0; two good frames (addr 1 then 2) -> first is held (`cmd_addr`=1), second is dropped (`frames_dropped`=1). Then assert `cmd_ready` -> `cmd_valid` falls next cycle. A third frame (addr 3) is then accepted.
- Robustness: assert `rst_n`=0 for one cycle at byte 30 of a good frame -> no counts, `cmd_valid`=0. The next good frame is accepted normally.
